flag_unit: RTL and testbench

Condition-flag register and branch-condition resolver for the CPU pipeline. It captures the N/Z/C/V flags produced by flag-setting ALU operations and holds them across non-flag-setting instructions. It evaluates B.cond, CBZ, CBNZ and B against either the stored flags or the flags being written in the same cycle. It also consumes the zero indication of the register operand for CBZ/CBNZ, and it keeps a saturating taken-branch counter for bring-up visibility.

---
 rtl/flag_unit.sv | 107 ++++++++++
 tb/tb_flag_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Condition-flag register and branch resolver: holds N/Z/C/V across non-flag-setting
// instructions, resolves B.cond/CBZ/CBNZ/B and counts taken branches (saturating).
module flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flag_we,
   input  logic             flush,
   input  logic             n_in,
   input  logic             z_in,
   input  logic             c_in,
   input  logic             v_in,
   input  logic             br_valid,
   input  logic [1:0]       br_type,
   input  logic [3:0]       cond,
   input  logic             reg_zero,
   output logic [3:0]       flags,
   output logic             br_taken,
   output logic             br_taken_q,
   output logic             br_valid_q,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      BR_COND = 2'b00,
      BR_CBZ  = 2'b01,
      BR_CBNZ = 2'b10,
      BR_UNC  = 2'b11
   } br_type_e;

   typedef enum logic [3:0] {
      CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_HS = 4'b0010, CC_LO = 4'b0011,
      CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
      CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
      CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
   } cond_e;

   logic       wr;
   logic [3:0] eff_flags;
   logic       f_n, f_z, f_c, f_v;
   logic       cond_met;
   logic       sel;
   logic       br_live;

   assign wr      = flag_we & ~flush;
   assign br_live = br_valid & ~flush & ~reset;

   // Same-cycle bypass so a branch paired with a flag write sees the new flags.
   assign eff_flags = wr ? {n_in, z_in, c_in, v_in} : flags;
   assign f_n = eff_flags[3];
   assign f_z = eff_flags[2];
   assign f_c = eff_flags[1];
   assign f_v = eff_flags[0];

   always_comb begin
      cond_met = 1'b1;
      case (cond_e'(cond))
         CC_EQ:   cond_met = f_z;
         CC_NE:   cond_met = ~f_z;
         CC_HS:   cond_met = f_c;
         CC_LO:   cond_met = ~f_c;
         CC_MI:   cond_met = f_n;
         CC_PL:   cond_met = ~f_n;
         CC_VS:   cond_met = f_v;
         CC_VC:   cond_met = ~f_v;
         CC_HI:   cond_met = f_c & ~f_z;
         CC_LS:   cond_met = ~f_c | f_z;
         CC_GE:   cond_met = (f_n == f_v);
         CC_LT:   cond_met = (f_n != f_v);
         CC_GT:   cond_met = ~f_z & (f_n == f_v);
         CC_LE:   cond_met = f_z | (f_n != f_v);
         default: cond_met = 1'b1;
      endcase
   end

   always_comb begin
      sel = 1'b0;
      case (br_type_e'(br_type))
         BR_COND: sel = cond_met;
         BR_CBZ:  sel = reg_zero;
         BR_CBNZ: sel = ~reg_zero;
         BR_UNC:  sel = 1'b1;
         default: sel = 1'b0;
      endcase
   end

   assign br_taken = br_live & sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         flags      <= 4'b0000;
         br_taken_q <= 1'b0;
         br_valid_q <= 1'b0;
         taken_cnt  <= '0;
      end else begin
         if (wr)
            flags <= {n_in, z_in, c_in, v_in};
         br_taken_q <= br_taken;
         br_valid_q <= br_live;
         // Saturate rather than wrap so a long bring-up run never reads as few branches.
         if (br_taken && (taken_cnt != {CNT_W{1'b1}}))
            taken_cnt <= taken_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: vector table with expected values, registered outputs checked
// through a scoreboard queue one edge after each drive.
module tb_flag_unit;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, flag_we, flush, n_in, z_in, c_in, v_in;
   logic          br_valid, reg_zero;
   logic [1:0]    br_type;
   logic [3:0]    cond;
   logic [3:0]    flags;
   logic          br_taken, br_taken_q, br_valid_q;
   logic [CW-1:0] taken_cnt;

   always #5 clk = ~clk;

   flag_unit #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .flag_we(flag_we), .flush(flush),
      .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
      .br_valid(br_valid), .br_type(br_type), .cond(cond), .reg_zero(reg_zero),
      .flags(flags), .br_taken(br_taken), .br_taken_q(br_taken_q),
      .br_valid_q(br_valid_q), .taken_cnt(taken_cnt)
   );

   typedef struct {
      logic       rst;
      logic       we;
      logic       fl;
      logic [3:0] nzcv;
      logic       bv;
      logic [1:0] bt;
      logic [3:0] cc;
      logic       rz;
      logic       exp_taken;
      logic [3:0] exp_flags;
   } vec_t;

   typedef struct {
      logic [3:0]    flags;
      logic          tq;
      logic          vq;
      logic [CW-1:0] cnt;
   } exp_t;

   vec_t          vt[$];
   exp_t          sb[$];
   int            checks = 0;
   int            failures = 0;
   logic [CW-1:0] cnt_m = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic we, input logic fl,
                               input logic [3:0] nzcv, input logic bv, input logic [1:0] bt,
                               input logic [3:0] cc, input logic rz,
                               input logic exp_taken, input logic [3:0] exp_flags);
      vec_t v;
      v.rst = rst; v.we = we; v.fl = fl; v.nzcv = nzcv; v.bv = bv; v.bt = bt;
      v.cc = cc; v.rz = rz; v.exp_taken = exp_taken; v.exp_flags = exp_flags;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      reset = v.rst; flag_we = v.we; flush = v.fl;
      {n_in, z_in, c_in, v_in} = v.nzcv;
      br_valid = v.bv; br_type = v.bt; cond = v.cc; reg_zero = v.rz;
      #1;
      chk({tag, " br_taken"}, 32'(br_taken), 32'(v.exp_taken));
      if (v.rst)
         cnt_m = '0;
      else if (v.exp_taken && cnt_m != '1)
         cnt_m = cnt_m + 1'b1;
      e.flags = v.exp_flags;
      e.tq    = v.exp_taken & ~v.rst;
      e.vq    = v.bv & ~v.fl & ~v.rst;
      e.cnt   = cnt_m;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, " flags"},      32'(flags),      32'(e.flags));
      chk({tag, " br_taken_q"}, 32'(br_taken_q), 32'(e.tq));
      chk({tag, " br_valid_q"}, 32'(br_valid_q), 32'(e.vq));
      chk({tag, " taken_cnt"},  32'(taken_cnt),  32'(e.cnt));
   endtask

   initial begin
      reset = 1'b1; flag_we = 1'b0; flush = 1'b0;
      {n_in, z_in, c_in, v_in} = 4'b0000;
      br_valid = 1'b0; br_type = 2'b00; cond = 4'b0000; reg_zero = 1'b0;

      //             rst we  fl  nzcv     bv  bt     cc       rz  tk  flags
      vt.push_back(mk(1, 1, 0, 4'b1111, 1, 2'b11, 4'b0000, 0, 0, 4'b0000));
      vt.push_back(mk(0, 1, 0, 4'b0100, 0, 2'b00, 4'b0000, 0, 0, 4'b0100));
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0000, 0, 1, 4'b0100)); // EQ stored
      vt.push_back(mk(0, 1, 0, 4'b0000, 1, 2'b00, 4'b0000, 0, 0, 4'b0000)); // EQ bypass
      vt.push_back(mk(0, 1, 0, 4'b1010, 0, 2'b00, 4'b0000, 0, 0, 4'b1010)); // N=1 C=1
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1011, 0, 1, 4'b1010)); // LT
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1010, 0, 0, 4'b1010)); // GE
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1100, 0, 0, 4'b1010)); // GT
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1101, 0, 1, 4'b1010)); // LE
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1000, 0, 1, 4'b1010)); // HI
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1001, 0, 0, 4'b1010)); // LS
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0010, 0, 1, 4'b1010)); // HS
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1110, 0, 1, 4'b1010)); // AL
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b1111, 0, 1, 4'b1010));
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0001, 0, 1, 4'b1010)); // NE
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0100, 0, 1, 4'b1010)); // MI
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0101, 0, 0, 4'b1010)); // PL
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0110, 0, 0, 4'b1010)); // VS
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0111, 0, 1, 4'b1010)); // VC
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0011, 0, 0, 4'b1010)); // LO
      vt.push_back(mk(0, 1, 0, 4'b0000, 0, 2'b00, 4'b0000, 0, 0, 4'b0000));
      vt.push_back(mk(0, 1, 1, 4'b1111, 1, 2'b00, 4'b0100, 0, 0, 4'b0000)); // flush
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0100, 0, 0, 4'b0000)); // MI stored
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b01, 4'b0000, 1, 1, 4'b0000)); // CBZ rz=1
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b10, 4'b0000, 1, 0, 4'b0000)); // CBNZ rz=1
      vt.push_back(mk(0, 1, 0, 4'b0100, 0, 2'b00, 4'b0000, 0, 0, 4'b0100));
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b01, 4'b0000, 0, 0, 4'b0100)); // CBZ, Z=1 rz=0
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b10, 4'b0001, 0, 1, 4'b0100)); // CBNZ rz=0
      vt.push_back(mk(0, 0, 1, 4'b0000, 1, 2'b11, 4'b0000, 0, 0, 4'b0100)); // B flushed
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b11, 4'b0001, 0, 1, 4'b0100)); // B
      vt.push_back(mk(0, 1, 0, 4'b1000, 0, 2'b00, 4'b0000, 0, 0, 4'b1000));
      vt.push_back(mk(0, 1, 0, 4'b0001, 0, 2'b00, 4'b0000, 0, 0, 4'b0001)); // last wins
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0100, 0, 0, 4'b0001)); // MI
      vt.push_back(mk(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0110, 0, 1, 4'b0001)); // VS
      vt.push_back(mk(1, 1, 0, 4'b1111, 1, 2'b11, 4'b0000, 0, 0, 4'b0000)); // reset mid-run

      for (int i = 0; i < vt.size(); i++)
         apply(vt[i], $sformatf("v%0d", i));

      // Counter saturation: 20 unconditional branches into a 4-bit counter.
      for (int i = 0; i < 20; i++)
         apply(mk(0, 0, 0, 4'b0000, 1, 2'b11, 4'b0000, 0, 1, 4'b0000), $sformatf("sat%0d", i));
      chk("sat final", 32'(taken_cnt), 32'd15);
      apply(mk(1, 0, 0, 4'b0000, 1, 2'b11, 4'b0000, 0, 0, 4'b0000), "sat reset");
      chk("cnt after reset", 32'(taken_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
